// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer.
// Optional jump support is selected with MC_JUMP_EN.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_en;
    } ctrl_t;

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath/memory bundle.
// master = controller, slave = datapath side.
interface mc_if;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       MemWrite;
    logic       IorD;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;
    logic       pc_en;
    logic       illegal_op;

    modport master (
        input  op, zero, mem_ready,
        output mem_req, MemWrite, IorD, IRWrite, RegDst, MemtoReg,
        output RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, pc_en, illegal_op
    );

    modport slave (
        output op, zero, mem_ready,
        input  mem_req, MemWrite, IorD, IRWrite, RegDst, MemtoReg,
        input  RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, pc_en, illegal_op
    );
endinterface

// File: rtl/mc_state_outputs.sv
// Moore output decode: state (+ready in FETCH, zero in BRANCH) -> controls.
// JUMP outputs exist only when MC_JUMP_EN is defined.
module mc_state_outputs
    import mc_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    input  logic   zero,
    output ctrl_t  ctrl
);

    ctrl_t c;
    logic  pc_write;
    logic  branch;

    // Per-state control values; unlisted states leave everything low
    always_comb begin
        c        = '0;
        pc_write = 1'b0;
        branch   = 1'b0;
        case (state)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.ir_write  = mem_ready;
                pc_write    = mem_ready;
            end
            S_DECODE: c.alu_src_b = SRCB_IMM_SH;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALUOP_SUB;
                c.pc_src    = PCSRC_ALUOUT;
                branch      = 1'b1;
            end
            S_ADDIEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: c.reg_write = 1'b1;
`ifdef MC_JUMP_EN
            S_JUMP: begin
                c.pc_src = PCSRC_JUMP;
                pc_write = 1'b1;
            end
`endif
            default: ;
        endcase
        c.pc_en = pc_write | (branch & zero);
    end

    // Jump-target select is only reachable with jump support built in
    always_comb begin
        ctrl = c;
`ifndef MC_JUMP_EN
        ctrl.pc_src[1] = 1'b0;
`endif
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: state register and next-state sequencing.
// Define MC_JUMP_EN to build the JUMP state for op 000010.
module multicycle_controller
    import mc_pkg::*;
(
    input  logic clk,
    input  logic reset,
    mc_if.master bus
);

    state_t state;
    state_t state_n;
    logic   illegal;
    logic   fetch_ready;
    ctrl_t  ctrl;

    // State register, synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_n;
    end

    // Next-state sequencing with memory stalls; bad encodings go to FETCH
    always_comb begin
        state_n = S_FETCH;
        illegal = 1'b0;
        case (state)
            S_FETCH:
                state_n = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:
                case (bus.op)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_RTYPE:     state_n = S_EXECUTE;
                    OP_BEQ:       state_n = S_BRANCH;
                    OP_ADDI:      state_n = S_ADDIEXEC;
`ifdef MC_JUMP_EN
                    OP_J:         state_n = S_JUMP;
`endif
                    default:      illegal = 1'b1;
                endcase
            S_MEMADR:
                state_n = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:
                state_n = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE:
                state_n = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  state_n = S_ALUWB;
            S_ADDIEXEC: state_n = S_ADDIWB;
            default:    state_n = S_FETCH;
        endcase
    end

    // Fetch write enables stay low while reset is held
    assign fetch_ready = bus.mem_ready & ~reset;

    mc_state_outputs u_outputs (
        .state     (state),
        .mem_ready (fetch_ready),
        .zero      (bus.zero),
        .ctrl      (ctrl)
    );

    assign bus.mem_req    = ctrl.mem_req;
    assign bus.MemWrite   = ctrl.mem_write;
    assign bus.IorD       = ctrl.iord;
    assign bus.IRWrite    = ctrl.ir_write;
    assign bus.RegDst     = ctrl.reg_dst;
    assign bus.MemtoReg   = ctrl.mem_to_reg;
    assign bus.RegWrite   = ctrl.reg_write;
    assign bus.ALUSrcA    = ctrl.alu_src_a;
    assign bus.ALUSrcB    = ctrl.alu_src_b;
    assign bus.ALUOp      = ctrl.alu_op;
    assign bus.PCSrc      = ctrl.pc_src;
    assign bus.pc_en      = ctrl.pc_en;
    assign bus.illegal_op = illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction phase model + random ops.
// Build with or without MC_JUMP_EN; expectations follow the same macro.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mc_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_total = 0;

    localparam logic [5:0] T_R    = 6'h00;
    localparam logic [5:0] T_LW   = 6'h23;
    localparam logic [5:0] T_SW   = 6'h2B;
    localparam logic [5:0] T_BEQ  = 6'h04;
    localparam logic [5:0] T_ADDI = 6'h08;
    localparam logic [5:0] T_J    = 6'h02;
    localparam logic [5:0] T_BAD  = 6'h3F;

    typedef enum {
        P_F, P_D, P_MA, P_MR, P_MWB, P_MWR,
        P_EX, P_AWB, P_BR, P_AX, P_IWB, P_J
    } ph_t;

    // {mem_req,MemWrite,IorD,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,
    //  ALUSrcB,ALUOp,PCSrc,pc_en,illegal_op}
    logic [16:0] act;
    assign act = {bus.mem_req, bus.MemWrite, bus.IorD, bus.IRWrite,
                  bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA,
                  bus.ALUSrcB, bus.ALUOp, bus.PCSrc, bus.pc_en,
                  bus.illegal_op};

    function automatic bit legal(logic [5:0] o);
        bit l;
        l = (o == T_R) || (o == T_LW) || (o == T_SW) ||
            (o == T_BEQ) || (o == T_ADDI);
`ifdef MC_JUMP_EN
        l = l || (o == T_J);
`endif
        return l;
    endfunction

    // Expected control word for a phase of an instruction
    function automatic logic [16:0] model(ph_t ph, logic rdy, logic z,
                                          logic [5:0] o);
        logic mreq, mw, iord, irw, rdst, m2r, rw, asa, pce, ill;
        logic [1:0] asb, aop, psrc;
        {mreq, mw, iord, irw, rdst, m2r, rw, asa, pce, ill} = '0;
        asb = 2'd0; aop = 2'd0; psrc = 2'd0;
        case (ph)
            P_F:   begin mreq = 1; asb = 2'd1; irw = rdy; pce = rdy; end
            P_D:   begin asb = 2'd3; ill = !legal(o); end
            P_MA:  begin asa = 1; asb = 2'd2; end
            P_MR:  begin mreq = 1; iord = 1; end
            P_MWB: begin rw = 1; m2r = 1; end
            P_MWR: begin mreq = 1; iord = 1; mw = 1; end
            P_EX:  begin asa = 1; aop = 2'd2; end
            P_AWB: begin rdst = 1; rw = 1; end
            P_BR:  begin asa = 1; aop = 2'd1; psrc = 2'd1; pce = z; end
            P_AX:  begin asa = 1; asb = 2'd2; end
            P_IWB: rw = 1;
            P_J:   begin psrc = 2'd2; pce = 1; end
            default: ;
        endcase
        return {mreq, mw, iord, irw, rdst, m2r, rw, asa, asb, aop, psrc,
                pce, ill};
    endfunction

    task automatic check(string name, logic [16:0] got, logic [16:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%05h expected=%05h", name, got, exp);
    endtask

    task automatic check_int(string name, int got, int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    endtask

    // One cycle: drive at posedge+1, compare at negedge, advance
    task automatic cyc(ph_t ph, logic rdy, logic [5:0] o, logic z);
        bus.mem_ready = rdy;
        bus.op = o;
        bus.zero = z;
        @(negedge clk);
        check($sformatf("cyc_%s_op%02h", ph.name(), o), act,
              model(ph, rdy, z, o));
        @(posedge clk);
        #1;
    endtask

    function automatic logic rz(int zs);
        if (zs == 2) return 1'($urandom);
        return 1'(zs);
    endfunction

    task automatic mem_phase(ph_t ph, int stalls, logic [5:0] o,
                             int zs, inout int n);
        int s;
        s = (stalls < 0) ? int'($urandom_range(0, 3)) : stalls;
        for (int k = 0; k < s; k++) cyc(ph, 1'b0, o, rz(zs));
        cyc(ph, 1'b1, o, rz(zs));
        n += s + 1;
    endtask

    task automatic plain(ph_t ph, logic [5:0] o, int zs, inout int n);
        cyc(ph, 1'($urandom), o, rz(zs));
        n++;
    endtask

    // Walk one instruction through its phases; n = cycles taken
    task automatic run_instr(logic [5:0] o, int fs, int ms, int zs,
                             output int n);
        n = 0;
        mem_phase(P_F, fs, 6'($urandom), zs, n);
        plain(P_D, o, zs, n);
        if (o == T_LW) begin
            plain(P_MA, o, zs, n);
            mem_phase(P_MR, ms, o, zs, n);
            plain(P_MWB, o, zs, n);
        end else if (o == T_SW) begin
            plain(P_MA, o, zs, n);
            mem_phase(P_MWR, ms, o, zs, n);
        end else if (o == T_R) begin
            plain(P_EX, o, zs, n);
            plain(P_AWB, o, zs, n);
        end else if (o == T_BEQ) begin
            plain(P_BR, o, zs, n);
        end else if (o == T_ADDI) begin
            plain(P_AX, o, zs, n);
            plain(P_IWB, o, zs, n);
`ifdef MC_JUMP_EN
        end else if (o == T_J) begin
            plain(P_J, o, zs, n);
`endif
        end
    endtask

    initial begin
        int n;
        int bad_lat;
        logic [5:0] ops [8];
        bus.mem_ready = 1'b1;
        bus.op = 6'd0;
        bus.zero = 1'b0;
        reset = 1'b1;

        // Model pins against hand-derived words
        check("pin_branch_z1", model(P_BR, 1'b0, 1'b1, T_BEQ),
              {8'b0000_0001, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0});
        check("pin_fetch_rdy", model(P_F, 1'b1, 1'b0, T_R),
              {8'b1001_0000, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0});

        // Reset held 3 cycles with mem_ready=1
        repeat (3) begin
            @(posedge clk);
            #1;
            check("in_reset", act, model(P_F, 1'b0, 1'b0, 6'd0));
        end
        reset = 1'b0;
        #1;
        check_int("rst_mem_req", int'(bus.mem_req), 1);
        check_int("rst_irwrite", int'(bus.IRWrite), 1);
        check_int("rst_pc_en", int'(bus.pc_en), 1);
        check_int("rst_alusrcb", int'(bus.ALUSrcB), 1);

        run_instr(T_LW, 0, 0, 2, n);
        check_int("lat_lw", n, 5);
        run_instr(T_SW, 0, 2, 2, n);
        check_int("lat_sw_stall2", n, 6);
        run_instr(T_R, 0, 0, 2, n);
        check_int("lat_rtype", n, 4);
        run_instr(T_ADDI, 0, 0, 2, n);
        check_int("lat_addi", n, 4);
        run_instr(T_BEQ, 0, 0, 1, n);
        check_int("lat_beq_z1", n, 3);
        run_instr(T_BEQ, 0, 0, 0, n);
        check_int("lat_beq_z0", n, 3);
        run_instr(T_BAD, 0, 0, 2, n);
        check_int("lat_illegal", n, 2);
        run_instr(T_J, 0, 0, 2, n);
`ifdef MC_JUMP_EN
        check_int("lat_j", n, 3);
`else
        check_int("lat_j_disabled", n, 2);
`endif

        // Reset during a stalled MEMREAD
        n = 0;
        mem_phase(P_F, 0, T_LW, 2, n);
        plain(P_D, T_LW, 2, n);
        plain(P_MA, T_LW, 2, n);
        bus.mem_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_int("rst_mid_regwrite", int'(bus.RegWrite), 0);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        #1;
        check("rst_mid_fetch", act, model(P_F, 1'b0, 1'b0, 6'd0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Random instruction stream
        ops[0] = T_R;  ops[1] = T_LW;   ops[2] = T_SW; ops[3] = T_BEQ;
        ops[4] = T_ADDI; ops[5] = T_J;  ops[6] = T_BAD; ops[7] = 6'd0;
        bad_lat = 0;
        for (int i = 0; i < 300; i++) begin
            logic [5:0] o;
            o = ops[$urandom_range(0, 7)];
            if (o == 6'd0 && ($urandom_range(0, 1) == 1))
                o = 6'($urandom);
            run_instr(o, -1, -1, 2, n);
            if (n < 2) bad_lat++;
        end
        check_int("rand_latency_floor", bad_lat, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control sequencer for the multi-cycle MIPS datapath. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback. In each state it drives the datapath mux selects and write enables. It stalls on a memory-ready handshake, so instruction and data fetches can take several cycles. It replaces per-opcode single-cycle decoding. ALU function decode (ALUOp plus funct) stays in the existing ALU decoder.

## Interface
- No parameters. Encodings are fixed in the shared package.
- clk: input, 1. Sole clock, rising edge.
- reset: input, 1. Synchronous, active-high.
- op: input, 6. Opcode field from the instruction register, valid from DECODE onward.
- zero: input, 1. ALU zero flag.
- mem_ready: input, 1. Memory has completed the current access this cycle.
- mem_req: output, 1. Memory access requested. High in FETCH, MEMREAD and MEMWRITE.
- MemWrite: output, 1. Store strobe. Equals mem_req in MEMWRITE.
- IorD: output, 1. Address select: 0 = PC, 1 = ALUOut.
- IRWrite: output, 1. Instruction register load.
- RegDst: output, 1. Write register select: 0 = rt, 1 = rd.
- MemtoReg: output, 1. Writeback data select: 0 = ALUOut, 1 = Data.
- RegWrite: output, 1. Register file write enable.
- ALUSrcA: output, 1. ALU A select: 0 = PC, 1 = register A.
- ALUSrcB: output, 2. ALU B select: 00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- ALUOp: output, 2. ALU operation: 00 = add, 01 = sub, 10 = use funct.
- PCSrc: output, 2. Next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- pc_en: output, 1. PC load enable: PCWrite | (Branch & zero).
- illegal_op: output, 1. Pulses in DECODE when op is unsupported.

## Operation
- Supported opcodes:
  - R-type: 000000
  - lw: 100011
  - sw: 101011
  - beq: 000100
  - addi: 001000
  - j: 000010 (see Configuration)
- State transitions:
  - FETCH -> DECODE when mem_ready.
  - DECODE branches on op:
    - lw/sw -> MEMADR
    - R-type -> EXECUTE
    - beq -> BRANCH
    - addi -> ADDIEXEC
    - j -> JUMP
    - anything else -> FETCH, with illegal_op=1
  - MEMADR -> MEMREAD (lw) or MEMWRITE (sw). op is re-sampled here.
  - MEMREAD -> MEMWB when mem_ready.
  - MEMWRITE -> FETCH when mem_ready.
  - EXECUTE -> ALUWB.
  - ADDIEXEC -> ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH and JUMP -> FETCH.
- Outputs per state. Anything not listed is 0 (ALUSrcB=00, ALUOp=00, PCSrc=00).
  - FETCH: mem_req=1, ALUSrcB=01. IRWrite = PCWrite = mem_ready.
  - DECODE: ALUSrcB=11 (branch target precompute).
  - MEMADR: ALUSrcA=1, ALUSrcB=10.
  - MEMREAD: mem_req=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1.
  - MEMWRITE: mem_req=1, IorD=1, MemWrite=1.
  - EXECUTE: ALUSrcA=1, ALUOp=10.
  - ALUWB: RegDst=1, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, Branch=1, PCSrc=01.
  - ADDIEXEC: ALUSrcA=1, ALUSrcB=10.
  - ADDIWB: RegWrite=1.
  - JUMP: PCWrite=1, PCSrc=10.
- Write enables (IRWrite, RegWrite, MemWrite, pc_en) are never asserted together with an unknown value. The FSM has no X default: unreachable state encodings recover to FETCH.

## Timing
- State is registered. Outputs are combinational from state, plus mem_ready in FETCH and zero in BRANCH. There is no output register.
- Reset: state=FETCH on the first clk edge with reset=1. While in reset, outputs take FETCH values with IRWrite=PCWrite=0. Reset has priority over any transition, including mid-instruction and mid-stall.
- Latency with mem_ready tied 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - addi: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
  - illegal op: 2 cycles
- Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. During the stall, mem_req and the address selects stay stable and all write enables stay 0. The exception is MemWrite, which stays high until the cycle in which mem_ready=1.
- mem_ready outside the memory states is ignored.
- beq: pc_en=zero in the BRANCH cycle only.

## Configuration
- MC_JUMP_EN defined: op 000010 goes DECODE -> JUMP -> FETCH, and PCSrc=10 is reachable.
- MC_JUMP_EN undefined: the JUMP state is not built, op 000010 is treated as illegal (illegal_op=1, return to FETCH), and PCSrc[1] is tied to 0.

## Structure
- The package `mc_pkg` holds:
  - the state enum (4-bit encoding)
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - ALUSrcB, ALUOp and PCSrc encoding constants
- Sub-module `mc_state_outputs` is purely combinational: state (+ mem_ready, zero) -> control vector.
- The top level holds the state register and next-state logic.

## Test plan
- Reset held 3 cycles with mem_ready=1 -> after release, state is FETCH: mem_req=1, IRWrite=1, pc_en=1, ALUSrcB=01.
- lw (op=100011), mem_ready=1 -> 5-cycle sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 and MemtoReg=1 only in cycle 5.
- sw (op=101011) with mem_ready=0 for the first 2 MEMWRITE cycles -> MemWrite=1 for 3 cycles, then FETCH. Total 6 cycles.
- beq (op=000100) run twice:
  - zero=1 -> pc_en=1 in cycle 3 with PCSrc=01.
  - zero=0 -> pc_en=0 throughout cycle 3.
- op=111111 -> illegal_op=1 in the DECODE cycle, and FETCH on the next cycle. Assert reset during MEMREAD -> FETCH on the next cycle, RegWrite never asserted.
- j (op=000010):
  - with MC_JUMP_EN -> JUMP state with PCSrc=10 and pc_en=1.
  - without it -> illegal_op=1, pc_en=0.
